// File: rtl/stack_controller_if.sv
// Handshake and memory-side signal bundle for the stack controller.
// slave is the controller's view; master is the requester/memory view.
interface stack_controller_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              full_flag;
    logic              empty_flag;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  req_valid, req_op, req_data, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_data,
               mem_addr, mem_wdata, mem_we, mem_re,
               full_flag, empty_flag, count
    );

    modport master (
        output req_valid, req_op, req_data, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_data,
               mem_addr, mem_wdata, mem_we, mem_re,
               full_flag, empty_flag, count
    );
endinterface

// File: rtl/stack_controller.sv
// Call/data stack sequencer: one push/pop/clear at a time, drives the stack
// region of data memory and keeps occupancy plus full/empty flags.
module stack_controller #(
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 8,
    parameter int              DEPTH      = 16,
    parameter logic [ADDR_W-1:0] STACK_BASE = 'hE0
) (
    input logic               clock,
    input logic               reset,
    stack_controller_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("stack_controller: DEPTH must be a power of two and at least 2");
    end
    if (int'(STACK_BASE) + DEPTH - 1 > (1 << ADDR_W) - 1) begin : gBadBase
        $error("stack_controller: stack region exceeds the address space");
    end

    typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              reqReady;
    logic              rspValid;
    logic              rspErr;
    logic [DATA_W-1:0] rspData;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memWe;
    logic              memRe;
    logic              fullFlag;
    logic              emptyFlag;

    assign fullFlag  = (count == CNT_W'(DEPTH));
    assign emptyFlag = (count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            reqReady <= 1'b1;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspData  <= '0;
            memAddr  <= '0;
            memWdata <= '0;
            memWe    <= 1'b0;
            memRe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        reqReady <= 1'b0;
                        if (bus.req_op == OP_PUSH && !fullFlag) begin
                            state    <= WRITE;
                            memWe    <= 1'b1;
                            memAddr  <= STACK_BASE + ADDR_W'(count);
                            memWdata <= bus.req_data;
                        end else if (bus.req_op == OP_POP && !emptyFlag) begin
                            state   <= READ;
                            memRe   <= 1'b1;
                            memAddr <= STACK_BASE + ADDR_W'(count) - ADDR_W'(1);
                        end else begin
                            // nop, clear, overflow and underflow all answer next cycle
                            state    <= RESP;
                            rspValid <= 1'b1;
                            rspErr   <= (bus.req_op == OP_PUSH) || (bus.req_op == OP_POP);
                            rspData  <= '0;
                            if (bus.req_op == OP_CLEAR) count <= '0;
                        end
                    end
                end
                WRITE: begin
                    memWe    <= 1'b0;
                    count    <= count + CNT_W'(1);
                    state    <= RESP;
                    rspValid <= 1'b1;
                    rspErr   <= 1'b0;
                    rspData  <= '0;
                end
                READ: begin
                    memRe <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rspData  <= bus.mem_rdata;
                    count    <= count - CNT_W'(1);
                    state    <= RESP;
                    rspValid <= 1'b1;
                    rspErr   <= 1'b0;
                end
                RESP: begin
                    rspValid <= 1'b0;
                    rspErr   <= 1'b0;
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.rsp_valid  = rspValid;
    assign bus.rsp_err    = rspErr;
    assign bus.rsp_data   = rspData;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;
    assign bus.mem_we     = memWe;
    assign bus.mem_re     = memRe;
    assign bus.full_flag  = fullFlag;
    assign bus.empty_flag = emptyFlag;
    assign bus.count      = count;
endmodule
